// File: rtl/ether_pkg.sv
// Shared definitions for the RMII Ethernet receive/transmit pair.
package ether_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD
  } rx_state_t;

  localparam int unsigned HDR_DIBITS = 56;
  localparam int unsigned DA_DIBITS  = 24;
  localparam int unsigned FCS_DIBITS = 16;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  // Reflected CRC-32 polynomial (bit 0 is the first bit on the wire)
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  // Advance the reflected CRC by one dibit; d[0] is the earlier bit in time
  function automatic logic [31:0] crc32_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ether_in_crc32.sv
// Dibit-serial CRC-32. axiod is the final FCS in emission order: the first
// dibit sent on the wire sits in [31:30], matching the receiver's delay line.
module crc32
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
);

  logic [31:0] crc_q;
  logic        axiov_q;

  // CRC accumulator: preset to all ones, advanced once per valid dibit
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q   <= '1;
      axiov_q <= 1'b0;
    end else if (axiiv) begin
      crc_q   <= crc32_dibit(crc_q, axiid);
      axiov_q <= 1'b1;
    end
  end

  // Invert and reorder into wire dibit order: dibit k = {c[2k+1], c[2k]}
  always_comb begin
    axiod = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      axiod[31-2*k] = ~crc_q[2*k+1];
      axiod[30-2*k] = ~crc_q[2*k];
    end
  end

  assign axiov = axiov_q;

endmodule

// File: rtl/ether_in.sv
// RMII frame receiver: preamble/SFD hunt, MAC header strip with DA filter and
// EtherType capture, FCS-stripped payload stream, end-of-frame status.
module ether_in
  import ether_pkg::*;
#(
  parameter logic [47:0] MY_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter int unsigned MIN_PREAMBLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic [15:0] ethertype,
  output logic        frame_done,
  output logic        fcs_ok,
  output logic        addr_ok
);

  localparam logic [5:0] DA_LAST   = 6'(DA_DIBITS - 1);
  localparam logic [5:0] ET_FIRST  = 6'(HDR_DIBITS - 8);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_DIBITS - 1);
  localparam logic [4:0] FILL_FULL = 5'(FCS_DIBITS);
  localparam logic [4:0] MIN_PRE   = 5'(MIN_PREAMBLE);

  rx_state_t   state_q, state_d;
  logic [4:0]  pre_cnt_q, pre_cnt_d;
  logic [5:0]  hdr_cnt_q, hdr_cnt_d;
  logic [45:0] da_sh_q, da_sh_d;
  logic        da_ok_q, da_ok_d;
  logic [13:0] et_sh_q, et_sh_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic [31:0] dl_q, dl_d;
  logic [4:0]  fill_q, fill_d;
  logic        axiov_q, axiov_d;
  logic [1:0]  axiod_q, axiod_d;
  logic        frame_done_q, frame_done_d;
  logic        fcs_ok_q, fcs_ok_d;
  logic        addr_ok_q, addr_ok_d;

  logic        crc_rst;
  logic        crc_in_v;
  logic [1:0]  crc_in_d;
  logic        crc_out_v;
  logic [31:0] crc_out;
  logic [1:0]  evict;
  logic [47:0] da_full;

  crc32 u_crc (
    .clk   (clk),
    .rst   (crc_rst),
    .axiiv (crc_in_v),
    .axiid (crc_in_d),
    .axiov (crc_out_v),
    .axiod (crc_out)
  );

  assign evict   = dl_q[31:30];
  assign da_full = {da_sh_q, rxd};

  // All state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_IDLE;
      pre_cnt_q    <= '0;
      hdr_cnt_q    <= '0;
      da_sh_q      <= '0;
      da_ok_q      <= 1'b0;
      et_sh_q      <= '0;
      ethertype_q  <= '0;
      dl_q         <= '0;
      fill_q       <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      frame_done_q <= 1'b0;
      fcs_ok_q     <= 1'b0;
      addr_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      da_sh_q      <= da_sh_d;
      da_ok_q      <= da_ok_d;
      et_sh_q      <= et_sh_d;
      ethertype_q  <= ethertype_d;
      dl_q         <= dl_d;
      fill_q       <= fill_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      frame_done_q <= frame_done_d;
      fcs_ok_q     <= fcs_ok_d;
      addr_ok_q    <= addr_ok_d;
    end
  end

  // Next-state, datapath and CRC feed selection
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    da_sh_d      = da_sh_q;
    da_ok_d      = da_ok_q;
    et_sh_d      = et_sh_q;
    ethertype_d  = ethertype_q;
    dl_d         = dl_q;
    fill_d       = fill_q;
    axiov_d      = 1'b0;
    axiod_d      = '0;
    frame_done_d = 1'b0;
    fcs_ok_d     = fcs_ok_q;
    addr_ok_d    = addr_ok_q;
    crc_rst      = 1'b0;
    crc_in_v     = 1'b0;
    crc_in_d     = rxd;

    case (state_q)
      WAIT_IDLE: begin
        crc_rst = 1'b1;
        if (!crsdv) state_d = IDLE;
      end

      IDLE: begin
        crc_rst = 1'b1;
        if (crsdv && rxd == PREAMBLE_DIBIT) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 5'd1;
        end
      end

      PREAMBLE: begin
        crc_rst = 1'b1;
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == PREAMBLE_DIBIT) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 5'd1;
        end else if (rxd == SFD_DIBIT && pre_cnt_q >= MIN_PRE) begin
          state_d   = HEADER;
          hdr_cnt_d = '0;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      HEADER: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else begin
          crc_in_v  = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q <= DA_LAST) da_sh_d = da_full[45:0];
          if (hdr_cnt_q == DA_LAST)
            da_ok_d = (da_full == MY_MAC) || (da_full == BCAST_MAC);
          if (hdr_cnt_q >= ET_FIRST) et_sh_d = {et_sh_q[11:0], rxd};
          if (hdr_cnt_q == HDR_LAST) begin
            ethertype_d = {et_sh_q, rxd};
            hdr_cnt_d   = '0;
            fill_d      = '0;
            state_d     = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (!crsdv) begin
          // Delay line now holds exactly the received FCS
          frame_done_d = 1'b1;
          fcs_ok_d     = (fill_q == FILL_FULL) && crc_out_v && (crc_out == dl_q);
          addr_ok_d    = da_ok_q;
          state_d      = IDLE;
        end else begin
          dl_d = {dl_q[29:0], rxd};
          if (fill_q == FILL_FULL) begin
            crc_in_v = 1'b1;
            crc_in_d = evict;
            axiov_d  = da_ok_q;
            axiod_d  = da_ok_q ? evict : 2'b00;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign ethertype  = ethertype_q;
  assign frame_done = frame_done_q;
  assign fcs_ok     = fcs_ok_q;
  assign addr_ok    = addr_ok_q;

endmodule

// File: tb/tb_ether_in.sv
// Directed bench for ether_in: a table of frame scenarios plus hand-written
// reset-mid-frame and back-to-back sequences.
module tb_ether_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic        axiov;
  logic [1:0]  axiod;
  logic [15:0] ethertype;
  logic        frame_done;
  logic        fcs_ok;
  logic        addr_ok;

  ether_in #(
    .MY_MAC       (48'hFFFF_FFFF_FFFF),
    .MIN_PREAMBLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .crsdv      (crsdv),
    .rxd        (rxd),
    .axiov      (axiov),
    .axiod      (axiod),
    .ethertype  (ethertype),
    .frame_done (frame_done),
    .fcs_ok     (fcs_ok),
    .addr_ok    (addr_ok)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: everything accumulates, the test reads it relative to a base
  logic [1:0] got_q[$];
  int         got_cyc[$];
  int         done_cnt = 0;
  logic       last_fcs = 1'b0;
  logic       last_addr = 1'b0;

  always @(negedge clk) begin
    if (axiov) begin
      got_q.push_back(axiod);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt  = done_cnt + 1;
      last_fcs  = fcs_ok;
      last_addr = addr_ok;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference CRC-32, reflected, bits fed in wire order (d[0] first)
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] != d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else              r = r >> 1;
    end
    return r;
  endfunction

  logic [1:0] fr[$];
  logic [1:0] pay[$];
  logic [1:0] exp_q[$];
  int         pay_start = 0;
  int         pay_cyc = 0;

  // ether_out-style frame: preamble, SFD, DA/SA/EtherType, payload 0,1,2.., FCS
  task automatic build(input logic [47:0] da, input logic [15:0] et, input int npay,
                       input int pre_len, input int flip_at);
    logic [47:0] sa;
    logic [31:0] c;
    logic [7:0]  b;
    sa = 48'h0212_3456_789A;
    fr.delete();
    pay.delete();
    c = '1;
    for (int i = 0; i < pre_len; i++) fr.push_back(2'b01);
    fr.push_back(2'b11);
    for (int i = 23; i >= 0; i--) begin fr.push_back(da[2*i+:2]); c = crc_model(c, da[2*i+:2]); end
    for (int i = 23; i >= 0; i--) begin fr.push_back(sa[2*i+:2]); c = crc_model(c, sa[2*i+:2]); end
    for (int i = 7; i >= 0; i--)  begin fr.push_back(et[2*i+:2]); c = crc_model(c, et[2*i+:2]); end
    pay_start = fr.size();
    for (int j = 0; j < npay; j++) begin
      b = 8'(j);
      for (int k = 0; k < 4; k++) begin
        fr.push_back(b[2*k+:2]);
        pay.push_back(b[2*k+:2]);
        c = crc_model(c, b[2*k+:2]);
      end
    end
    c = ~c;
    for (int k = 0; k < 16; k++) fr.push_back({c[2*k+1], c[2*k]});
    if (flip_at >= 0) begin
      fr[pay_start+flip_at]  = fr[pay_start+flip_at] ^ 2'b10;
      pay[flip_at]           = pay[flip_at] ^ 2'b10;
    end
  endtask

  // Drive fr[first..last-1] with carrier, then `gap` idle cycles
  task automatic send(input int last, input int first, input int gap);
    for (int i = first; i < last; i++) begin
      @(posedge clk); #1;
      crsdv = 1'b1;
      rxd   = fr[i];
      if (i == pay_start) pay_cyc = cyc;
    end
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      crsdv = 1'b0;
      rxd   = 2'b00;
    end
  endtask

  task automatic check_frame(input string tag, input int bg, input int bd, input int exp_n,
                             input int exp_done, input int exp_fcs, input int exp_addr,
                             input logic [15:0] exp_et, input bit chk_lat);
    int n;
    int mism;
    n = got_q.size() - bg;
    check({tag, " axiov count"}, n, exp_n);
    if (exp_n > 0 && n == exp_n) begin
      mism = 0;
      for (int i = 0; i < n; i++) if (got_q[bg+i] !== exp_q[i]) mism++;
      check({tag, " payload dibit errors"}, mism, 0);
      if (chk_lat) check({tag, " latency"}, got_cyc[bg] - pay_cyc, 17);
    end
    check({tag, " frame_done count"}, done_cnt - bd, exp_done);
    if (exp_done > 0) begin
      check({tag, " fcs_ok"}, int'(last_fcs), exp_fcs);
      check({tag, " addr_ok"}, int'(last_addr), exp_addr);
    end
    check({tag, " ethertype"}, int'(ethertype), int'(exp_et));
  endtask

  typedef struct {
    logic [47:0] da;
    logic [15:0] et;
    int          npay;
    int          pre_len;
    int          flip_at;
    int          cut;       // payload dibits sent before carrier drops, -1 = whole frame
    int          exp_n;
    int          exp_done;
    int          exp_fcs;
    int          exp_addr;
    logic [15:0] exp_et;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bg;
    int bd;
    int last;

    vecs[0] = '{48'hFFFF_FFFF_FFFF, 16'h0800, 46, 31, -1, -1, 184, 1, 1, 1, 16'h0800};
    vecs[1] = '{48'hFFFF_FFFF_FFFF, 16'h0800, 46, 31, 37, -1, 184, 1, 0, 1, 16'h0800};
    vecs[2] = '{48'h0200_0000_0001, 16'h9000, 46, 31, -1, -1,   0, 1, 1, 0, 16'h9000};
    vecs[3] = '{48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 31, -1, 10,   0, 1, 0, 1, 16'h88B5};
    vecs[4] = '{48'hFFFF_FFFF_FFFF, 16'h1234,  2, 16, -1, -1,   8, 1, 1, 1, 16'h1234};
    vecs[5] = '{48'hFFFF_FFFF_FFFF, 16'h5555, 46, 15, -1, -1,   0, 0, 0, 0, 16'h1234};
    vecs[6] = '{48'hFFFF_FFFF_FFFF, 16'h6666, 46,  8, -1, -1,   0, 0, 0, 0, 16'h1234};
    vecs[7] = '{48'hFFFF_FFFF_FFFF, 16'h86DD, 46, 31, -1, -1, 184, 1, 1, 1, 16'h86DD};
    vecs[8] = '{48'hFFFF_FFFF_FFFF, 16'h0806,  0, 31, -1, -1,   0, 1, 1, 1, 16'h0806};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset axiov", int'(axiov), 0);
    check("reset axiod", int'(axiod), 0);
    check("reset ethertype", int'(ethertype), 0);
    check("reset status", int'({frame_done, fcs_ok, addr_ok}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      build(vecs[v].da, vecs[v].et, vecs[v].npay, vecs[v].pre_len, vecs[v].flip_at);
      exp_q = pay;
      bg = got_q.size();
      bd = done_cnt;
      last = (vecs[v].cut < 0) ? fr.size() : pay_start + vecs[v].cut;
      send(last, 0, 30);
      check_frame($sformatf("vec%0d", v), bg, bd, vecs[v].exp_n, vecs[v].exp_done,
                  vecs[v].exp_fcs, vecs[v].exp_addr, vecs[v].exp_et, 1'b1);
    end

    // Async reset mid-payload, released while carrier is still present
    build(48'hFFFF_FFFF_FFFF, 16'h0800, 46, 31, -1);
    send(pay_start + 50, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset axiov", int'(axiov), 0);
    check("midreset outputs", int'({axiod, frame_done, fcs_ok, addr_ok}), 0);
    check("midreset ethertype", int'(ethertype), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bg = got_q.size();
    bd = done_cnt;
    send(fr.size(), pay_start + 51, 30);
    check("after reset axiov count", got_q.size() - bg, 0);
    check("after reset frame_done count", done_cnt - bd, 0);
    build(48'hFFFF_FFFF_FFFF, 16'h0801, 46, 31, -1);
    exp_q = pay;
    bg = got_q.size();
    bd = done_cnt;
    send(fr.size(), 0, 30);
    check_frame("post-reset frame", bg, bd, 184, 1, 1, 1, 16'h0801, 1'b1);

    // Back-to-back frames with a single idle cycle between them
    build(48'hFFFF_FFFF_FFFF, 16'hAAAA, 46, 31, -1);
    exp_q = pay;
    bg = got_q.size();
    bd = done_cnt;
    send(fr.size(), 0, 1);
    build(48'hFFFF_FFFF_FFFF, 16'hBBBB, 46, 31, -1);
    for (int i = 0; i < pay.size(); i++) exp_q.push_back(pay[i]);
    send(fr.size(), 0, 30);
    check_frame("back-to-back", bg, bd, 368, 2, 1, 1, 16'hBBBB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
